// File: rtl/countdown8_pkg.sv
// Shared definitions for the countdown8 loadable down-counter/timer.
//   CD_WIDTH   : default counter/load width in bits
//   cd_state_e : FSM state encoding (also visible on the debug state port)
package countdown8_pkg;

  localparam int unsigned CD_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } cd_state_e;

endpackage

// File: rtl/countdown8_dp.sv
// Datapath for countdown8: count register, reload register, WIDTH+1 bit
// decrementer and the registered borrow pulse. All sequencing decisions come
// from the FSM in countdown8 through the enable inputs.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   load_en_i        capture load_val_i into count and reload registers
//   load_val_i       value to capture
//   dec_en_i         decrement (or underflow-handle) the count this cycle
//   reload_en_i      copy reload register into the count (restart from DONE)
//   auto_reload_i    on underflow: 1 reload the count, 0 hold it at zero
//   out_o            current count
//   borrow_o         one-cycle underflow pulse
//   zero_o           count is zero (combinational, for the FSM)
//   reload_zero_o    reload register is zero (combinational, for the FSM)
module countdown8_dp
  import countdown8_pkg::*;
#(
  parameter int unsigned WIDTH = CD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_en_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_en_i,
  input  logic             reload_en_i,
  input  logic             auto_reload_i,
  output logic [WIDTH-1:0] out_o,
  output logic             borrow_o,
  output logic             zero_o,
  output logic             reload_zero_o
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH:0]   diff;

  // Extra top bit catches the underflow instead of letting the count wrap.
  assign diff = {1'b0, out_q} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    out_d    = out_q;
    reload_d = reload_q;
    borrow_d = 1'b0;
    if (load_en_i) begin
      out_d    = load_val_i;
      reload_d = load_val_i;
    end else if (reload_en_i) begin
      out_d = reload_q;
    end else if (dec_en_i) begin
      if (diff[WIDTH]) begin
        borrow_d = 1'b1;
        out_d    = auto_reload_i ? reload_q : '0;
      end else begin
        out_d = diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q    <= '0;
      reload_q <= '0;
      borrow_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
    end
  end

  assign out_o         = out_q;
  assign borrow_o      = borrow_q;
  assign zero_o        = (out_q == '0);
  assign reload_zero_o = (reload_q == '0);

endmodule

// File: rtl/countdown8.sv
// Loadable down-counter/timer. Counts a loaded value down to zero, pulses
// borrow for one cycle on underflow, and either reloads (periodic tick) or
// stops in DONE. Per-cycle priority: reset > load > stop > start.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   load, load_val      load strobe and value (count and reload registers)
//   start, stop         begin/resume and pause counting
//   auto_reload         sampled on the underflow cycle only
//   out                 current count
//   borrow              one-cycle underflow pulse
//   done                level: non-reload countdown finished
//   busy                level: state is RUN or HOLD
//   dbg_state_o         current FSM state (cd_state_e encoding)
// Handshake: none; all inputs are level-sampled on every rising clk edge and
// every effect is visible on the registered outputs after that edge.
module countdown8
  import countdown8_pkg::*;
#(
  parameter int unsigned WIDTH = CD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  cd_state_e state_q;
  logic      done_q;
  logic      busy_q;
  logic      dec_en;
  logic      reload_en;
  logic      zero;
  logic      reload_zero;

  // Decrement only while running and not overridden by load or stop.
  assign dec_en    = !load && !stop && (state_q == ST_RUN);
  // Restart from DONE copies the reload value (zero if reload is zero).
  assign reload_en = !load && !stop && start && (state_q == ST_DONE);

  countdown8_dp #(.WIDTH(WIDTH)) u_dp (
    .clk_i         (clk),
    .rst_i         (reset),
    .load_en_i     (load),
    .load_val_i    (load_val),
    .dec_en_i      (dec_en),
    .reload_en_i   (reload_en),
    .auto_reload_i (auto_reload),
    .out_o         (out),
    .borrow_o      (borrow),
    .zero_o        (zero),
    .reload_zero_o (reload_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (load) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (stop) begin
      // Stop only has an effect while running; busy stays high in HOLD.
      if (state_q == ST_RUN) begin
        state_q <= ST_HOLD;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (zero) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // Underflow without auto-reload ends the countdown.
          if (zero && !auto_reload) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (start) begin
            state_q <= ST_RUN;
          end
        end
        ST_DONE: begin
          if (start && !reload_zero) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign done        = done_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_countdown8.sv
module tb_countdown8;
  import countdown8_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic [W-1:0] load_val;
  logic         start;
  logic         stop;
  logic         auto_reload;
  logic [W-1:0] out;
  logic         borrow;
  logic         done;
  logic         busy;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  countdown8 #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_val    (load_val),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
    .out         (out),
    .borrow      (borrow),
    .done        (done),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 run, 2 hold, 3 done
  int m_out, m_rel, m_mode;
  bit m_borrow, m_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out = 0; m_rel = 0; m_mode = 0; m_borrow = 0; m_done = 0;
    end else begin
      m_borrow = 0;
      if (load) begin
        m_out = int'(load_val); m_rel = int'(load_val); m_mode = 0; m_done = 0;
      end else if (stop) begin
        if (m_mode == 1) m_mode = 2;
      end else begin
        if (m_mode == 1) begin
          if (m_out > 0) m_out = m_out - 1;
          else begin
            m_borrow = 1;
            if (auto_reload) m_out = m_rel;
            else begin m_mode = 3; m_done = 1; end
          end
        end else if (m_mode == 0 && start) begin
          if (m_out == 0) begin m_mode = 3; m_done = 1; end
          else m_mode = 1;
        end else if (m_mode == 2 && start) begin
          m_mode = 1;
        end else if (m_mode == 3 && start) begin
          m_out = m_rel;
          if (m_rel != 0) begin m_mode = 1; m_done = 0; end
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      cmp("model_out",    32'(out),       32'(m_out));
      cmp("model_borrow", 32'(borrow),    32'(m_borrow));
      cmp("model_done",   32'(done),      32'(m_done));
      cmp("model_busy",   32'(busy),      32'((m_mode == 1) || (m_mode == 2)));
      cmp("model_state",  32'(dbg_state), 32'(m_mode));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v; start = 1'b0; stop = 1'b0;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  logic [W-1:0] seq_out [9];
  logic         seq_b   [9];

  initial begin
    reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; stop = 1'b0;
    auto_reload = 1'b0;
    steps(2);
    cmp("reset_out",  32'(out),  32'd0);
    cmp("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    // Async reset mid-RUN at out=5
    do_load(8'd8);
    do_start();
    steps(3);
    cmp("t1_pre_out", 32'(out), 32'd5);
    cmp("t1_pre_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    cmp("t1_out",    32'(out),       32'd0);
    cmp("t1_borrow", 32'(borrow),    32'd0);
    cmp("t1_done",   32'(done),      32'd0);
    cmp("t1_busy",   32'(busy),      32'd0);
    cmp("t1_state",  32'(dbg_state), 32'(ST_IDLE));
    step();
    reset = 1'b0;
    step();

    // One-shot countdown from 3
    auto_reload = 1'b0;
    do_load(8'd3);
    cmp("t2_load_out", 32'(out), 32'd3);
    do_start();
    cmp("t2_out3", 32'(out), 32'd3);
    cmp("t2_busy", 32'(busy), 32'd1);
    step(); cmp("t2_out2", 32'(out), 32'd2);
    step(); cmp("t2_out1", 32'(out), 32'd1);
    step(); cmp("t2_out0", 32'(out), 32'd0);
    cmp("t2_borrow_early", 32'(borrow), 32'd0);
    step();
    cmp("t2_borrow", 32'(borrow), 32'd1);
    cmp("t2_done",   32'(done),   32'd1);
    cmp("t2_busy_f", 32'(busy),   32'd0);
    cmp("t2_out_z",  32'(out),    32'd0);
    step();
    cmp("t2_borrow_1w", 32'(borrow), 32'd0);
    cmp("t2_done_hold", 32'(done),   32'd1);

    // Auto-reload period 3
    seq_out = '{8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0, 8'd2, 8'd1, 8'd0};
    seq_b   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    auto_reload = 1'b1;
    do_load(8'd2);
    do_start();
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      cmp("t3_out",    32'(out),    32'(seq_out[i]));
      cmp("t3_borrow", 32'(borrow), 32'(seq_b[i]));
      cmp("t3_done",   32'(done),   32'd0);
    end
    auto_reload = 1'b0;

    // Stop/hold at 0x80, stop beats start, resume
    do_load(8'hFF);
    do_start();
    cmp("t4_out_ff", 32'(out), 32'hFF);
    steps(127);
    cmp("t4_out_80", 32'(out), 32'h80);
    for (int i = 0; i < 4; i++) begin
      stop = 1'b1;
      start = (i == 2);
      step();
      cmp("t4_hold_out",  32'(out),  32'h80);
      cmp("t4_hold_busy", 32'(busy), 32'd1);
      cmp("t4_hold_st",   32'(dbg_state), 32'(ST_HOLD));
    end
    stop = 1'b0;
    do_start();
    cmp("t4_resume_80", 32'(out), 32'h80);
    cmp("t4_resume_st", 32'(dbg_state), 32'(ST_RUN));
    step();
    cmp("t4_out_7f", 32'(out), 32'h7F);

    // Load 0 then start: DONE, no borrow; restart with reload 0 stays DONE
    do_load(8'd0);
    do_start();
    cmp("t5_done",   32'(done),   32'd1);
    cmp("t5_borrow", 32'(borrow), 32'd0);
    cmp("t5_busy",   32'(busy),   32'd0);
    do_start();
    cmp("t5_again_done", 32'(done),      32'd1);
    cmp("t5_again_st",   32'(dbg_state), 32'(ST_DONE));
    cmp("t5_again_b",    32'(borrow),    32'd0);
    do_load(8'd4);
    cmp("t5_load_done", 32'(done),      32'd0);
    cmp("t5_load_out",  32'(out),       32'd4);
    cmp("t5_load_st",   32'(dbg_state), 32'(ST_IDLE));

    // Restart from DONE with reload 6, then load mid-RUN
    do_load(8'd6);
    do_start();
    steps(7);
    cmp("t6_done",   32'(done),   32'd1);
    cmp("t6_borrow", 32'(borrow), 32'd1);
    do_start();
    cmp("t6_out6",  32'(out),       32'd6);
    cmp("t6_done0", 32'(done),      32'd0);
    cmp("t6_st",    32'(dbg_state), 32'(ST_RUN));
    step();
    cmp("t6_out5", 32'(out), 32'd5);
    do_load(8'd9);
    cmp("t6_out9", 32'(out),       32'd9);
    cmp("t6_busy", 32'(busy),      32'd0);
    cmp("t6_idle", 32'(dbg_state), 32'(ST_IDLE));
    steps(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
